// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO-to-stream read path.
package fifo_rd_pkg;

   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned OCC_W     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   // True when the buffer still has a free slot once the in-flight word
   // lands and this cycle's transfer (if any) leaves.
   function automatic logic room_after(input logic [OCC_W-1:0] occ,
                                       input logic             pend,
                                       input logic             xfer);
      logic [OCC_W:0] fill;
      fill = {1'b0, occ} + {{OCC_W{1'b0}}, pend} - {{OCC_W{1'b0}}, xfer};
      return fill < (OCC_W+1)'(BUF_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO pop side and outgoing stream handshake bundled for fifo_rd_stream.
interface fifo_rd_stream_if #(
   parameter int unsigned DWIDTH = 8
);
   logic              fifo_empty;
   logic [DWIDTH-1:0] fifo_dout;
   logic              fifo_pop;
   logic              m_valid;
   logic [DWIDTH-1:0] m_data;
   logic              m_ready;

   modport master (
      input  fifo_empty, fifo_dout, m_ready,
      output fifo_pop, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_dout, m_ready,
      input  fifo_pop, m_valid, m_data
   );
endinterface

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// Two-entry in-order holding buffer; entry 0 is always the oldest word.
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [DWIDTH-1:0] din,
   input  logic              pop,
   output logic [DWIDTH-1:0] dout,
   output logic [OCC_W-1:0]  occ
);

   logic [DWIDTH-1:0] ent0;
   logic [DWIDTH-1:0] ent1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ent0 <= '0;
         ent1 <= '0;
         occ  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == '0) ent0 <= din;
               else           ent1 <= din;
               occ <= occ + OCC_W'(1);
            end
            2'b01: begin
               ent0 <= ent1;
               occ  <= occ - OCC_W'(1);
            end
            2'b11: begin
               // Head leaves while a word arrives: occupancy is unchanged.
               if (occ == OCC_W'(BUF_DEPTH)) begin
                  ent0 <= ent1;
                  ent1 <= din;
               end else begin
                  ent0 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout = ent0;

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered read data and a sticky underflow flag.
module sync_fifo #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [DWIDTH-1:0] din,
   output logic              full,
   input  logic              pop,
   output logic [DWIDTH-1:0] dout,
   output logic              empty,
   output logic              underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [CW-1:0]     cnt;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr      <= '0;
         rptr      <= '0;
         cnt       <= '0;
         dout      <= '0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + AW'(1);
         if (pop_ok) begin
            dout <= mem[rptr];
            rptr <= rptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: ;
         endcase
         if (pop && empty) underflow <= 1'b1;
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops a FIFO whose read data lags the pop by one cycle and presents the
// words as a valid/ready stream without drops, repeats or reordering.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                en,
   fifo_rd_stream_if.master    bus,
   output logic                busy,
   output logic [CNT_W-1:0]    xfer_cnt
);

   rd_state_t         state;
   rd_state_t         state_nxt;
   logic              pend;
   logic [OCC_W-1:0]  occ;
   logic              xfer;
   logic              pop_req;
   logic [DWIDTH-1:0] buf_dout;

   assign bus.m_valid = (occ != '0);
   assign bus.m_data  = buf_dout;
   assign xfer        = bus.m_valid & bus.m_ready;

   // Pend covers the one-cycle gap between an accepted pop and its data.
   assign pop_req = (state == RUN) & en & ~bus.fifo_empty &
                    room_after(occ, pend, xfer);
   assign bus.fifo_pop = pop_req;
   assign busy         = (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (en) state_nxt = RUN;
         end
         RUN: begin
            if (!en) state_nxt = ((occ != '0) || pend) ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (en)                          state_nxt = RUN;
            else if ((occ == '0) && !pend)   state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend     <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         pend <= pop_req & ~bus.fifo_empty;
         if (xfer) xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

   rd_skid_buf #(
      .DWIDTH (DWIDTH)
   ) u_buf (
      .clk  (clk),
      .rstn (rstn),
      .push (pend),
      .din  (bus.fifo_dout),
      .pop  (xfer),
      .dout (buf_dout),
      .occ  (occ)
   );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: sync_fifo push side driven by stimulus, fifo_rd_stream reads it.
module tb_fifo_rd_stream;
   import fifo_rd_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       en = 1'b0;
   logic       push = 1'b0;
   logic [7:0] din = '0;
   logic       full;
   logic       underflow;
   logic       busy;
   logic [3:0] xfer_cnt;

   int unsigned total = 0;
   int unsigned bad = 0;

   fifo_rd_stream_if #(.DWIDTH(8)) bus ();

   sync_fifo #(.DWIDTH(8), .DEPTH(4)) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .din       (din),
      .full      (full),
      .pop       (bus.fifo_pop),
      .dout      (bus.fifo_dout),
      .empty     (bus.fifo_empty),
      .underflow (underflow)
   );

   fifo_rd_stream #(.DWIDTH(8), .CNT_W(4)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .bus      (bus.master),
      .busy     (busy),
      .xfer_cnt (xfer_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic do_reset;
      rstn = 1'b0; en = 1'b0; push = 1'b0; din = '0; bus.m_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic push_words(input int unsigned n, input logic [7:0] first);
      for (int unsigned i = 0; i < n; i++) begin
         push = 1'b1;
         din  = first + 8'(i);
         @(posedge clk);
         #1;
      end
      push = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      @(negedge clk);
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", bus.m_valid); end
      total++; if (bus.m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%0h exp=0", bus.m_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      total++; if (bus.fifo_pop !== 1'b0) begin bad++; $display("FAIL reset_pop got=%0b exp=0", bus.fifo_pop); end
      total++; if (xfer_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); end
   endtask

   task automatic test_stream;
      int unsigned got = 0;
      int unsigned last = 0;
      do_reset;
      bus.m_ready = 1'b1;
      push_words(4, 8'h01);
      en = 1'b1;
      for (int unsigned c = 0; c < 20 && got < 4; c++) begin
         @(negedge clk);
         total++; if (bus.fifo_pop && bus.fifo_empty) begin bad++; $display("FAIL stream_pop_empty got=1 exp=0"); end
         if (bus.m_valid) begin
            total++; if (bus.m_data !== 8'(got + 1)) begin bad++; $display("FAIL stream_data got=%0h exp=%0h", bus.m_data, 8'(got + 1)); end
            total++;
            if (got == 0) begin
               if (c != 3) begin bad++; $display("FAIL stream_latency got=%0d exp=3", c); end
            end else if (c != last + 1) begin
               bad++; $display("FAIL stream_gap got=%0d exp=%0d", c, last + 1);
            end
            last = c;
            got++;
         end
         @(posedge clk);
         #1;
      end
      total++; if (got != 4) begin bad++; $display("FAIL stream_count got=%0d exp=4", got); end
      total++; if (xfer_cnt !== 4'd4) begin bad++; $display("FAIL stream_xfer_cnt got=%0d exp=4", xfer_cnt); end
      en = 1'b0;
      for (int unsigned k = 0; k < 4 && busy; k++) begin
         @(posedge clk);
         #1;
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stream_busy_fall got=%0b exp=0", busy); end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL stream_underflow got=%0b exp=0", underflow); end
   endtask

   task automatic test_backpressure;
      int unsigned pops = 0;
      int unsigned got = 0;
      do_reset;
      bus.m_ready = 1'b0;
      push_words(4, 8'h01);
      en = 1'b1;
      for (int unsigned c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.fifo_pop && !bus.fifo_empty) pops++;
         if (bus.m_valid) begin
            total++; if (bus.m_data !== 8'h01) begin bad++; $display("FAIL bp_stable got=%0h exp=01", bus.m_data); end
         end
         @(posedge clk);
         #1;
      end
      total++; if (pops != 2) begin bad++; $display("FAIL bp_pops got=%0d exp=2", pops); end
      total++; if (dut.occ !== 2'd2) begin bad++; $display("FAIL bp_occ got=%0d exp=2", dut.occ); end
      total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%0b exp=1", bus.m_valid); end
      bus.m_ready = 1'b1;
      for (int unsigned c = 0; c < 20 && got < 4; c++) begin
         @(negedge clk);
         if (bus.m_valid) begin
            total++; if (bus.m_data !== 8'(got + 1)) begin bad++; $display("FAIL bp_order got=%0h exp=%0h", bus.m_data, 8'(got + 1)); end
            got++;
         end
         @(posedge clk);
         #1;
      end
      total++; if (got != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got); end
   endtask

   task automatic test_empty;
      do_reset;
      en = 1'b1;
      bus.m_ready = 1'b1;
      for (int unsigned c = 0; c < 20; c++) begin
         @(negedge clk);
         total++; if (bus.fifo_pop !== 1'b0) begin bad++; $display("FAIL empty_pop cyc=%0d got=%0b exp=0", c, bus.fifo_pop); end
         total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL empty_valid cyc=%0d got=%0b exp=0", c, bus.m_valid); end
         @(posedge clk);
         #1;
      end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL empty_underflow got=%0b exp=0", underflow); end
   endtask

   task automatic test_drain;
      int unsigned got = 0;
      do_reset;
      bus.m_ready = 1'b0;
      push_words(4, 8'h01);
      en = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      total++; if (dut.occ !== 2'd1 || dut.pend !== 1'b1) begin bad++; $display("FAIL drain_setup got occ=%0d pend=%0b exp occ=1 pend=1", dut.occ, dut.pend); end
      en = 1'b0;
      @(negedge clk);
      total++; if (bus.fifo_pop !== 1'b0) begin bad++; $display("FAIL drain_pop_off got=%0b exp=0", bus.fifo_pop); end
      @(posedge clk);
      #1;
      total++; if (dut.state !== DRAIN) begin bad++; $display("FAIL drain_state got=%0d exp=%0d", dut.state, DRAIN); end
      total++; if (dut.occ !== 2'd2) begin bad++; $display("FAIL drain_occ got=%0d exp=2", dut.occ); end
      bus.m_ready = 1'b1;
      for (int unsigned c = 0; c < 10; c++) begin
         @(negedge clk);
         total++; if (bus.fifo_pop !== 1'b0) begin bad++; $display("FAIL drain_no_pop cyc=%0d got=%0b exp=0", c, bus.fifo_pop); end
         if (bus.m_valid) begin
            total++; if (bus.m_data !== 8'(got + 1)) begin bad++; $display("FAIL drain_data got=%0h exp=%0h", bus.m_data, 8'(got + 1)); end
            got++;
         end
         @(posedge clk);
         #1;
      end
      total++; if (got != 2) begin bad++; $display("FAIL drain_count got=%0d exp=2", got); end
      total++; if (dut.state !== IDLE) begin bad++; $display("FAIL drain_idle got=%0d exp=%0d", dut.state, IDLE); end
      total++; if (xfer_cnt !== 4'd2) begin bad++; $display("FAIL drain_xfer_cnt got=%0d exp=2", xfer_cnt); end
   endtask

   task automatic test_reset_mid;
      logic found = 1'b0;
      do_reset;
      bus.m_ready = 1'b1;
      push_words(4, 8'h01);
      en = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      bus.m_ready = 1'b0;
      total++; if (dut.occ !== 2'd1 || dut.pend !== 1'b1) begin bad++; $display("FAIL rmid_setup got occ=%0d pend=%0b exp occ=1 pend=1", dut.occ, dut.pend); end
      total++; if (xfer_cnt !== 4'd1) begin bad++; $display("FAIL rmid_pre_cnt got=%0d exp=1", xfer_cnt); end
      rstn = 1'b0;
      #1;
      total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b exp=0", bus.m_valid); end
      total++; if (xfer_cnt !== 4'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", xfer_cnt); end
      total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rmid_state got=%0d exp=%0d", dut.state, IDLE); end
      total++; if (bus.m_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%0h exp=0", bus.m_data); end
      @(posedge clk);
      #1 rstn = 1'b1;
      bus.m_ready = 1'b1;
      for (int unsigned c = 0; c < 6; c++) begin
         @(negedge clk);
         total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale cyc=%0d got=%0b exp=0", c, bus.m_valid); end
         @(posedge clk);
         #1;
      end
      push_words(1, 8'h55);
      for (int unsigned c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (bus.m_valid) begin
            found = 1'b1;
            total++; if (bus.m_data !== 8'h55) begin bad++; $display("FAIL rmid_fresh got=%0h exp=55", bus.m_data); end
         end
         @(posedge clk);
         #1;
      end
      total++; if (!found) begin bad++; $display("FAIL rmid_timeout got=none exp=55"); end
   endtask

   task automatic test_wrap;
      int unsigned sent = 0;
      int unsigned got = 0;
      do_reset;
      bus.m_ready = 1'b1;
      en = 1'b1;
      for (int unsigned c = 0; c < 150 && got < 17; c++) begin
         @(posedge clk);
         #1;
         push = !full && (sent < 17);
         if (push) begin
            din = 8'h10 + 8'(sent);
            sent++;
         end
         @(negedge clk);
         if (bus.m_valid) begin
            total++; if (bus.m_data !== 8'h10 + 8'(got)) begin bad++; $display("FAIL wrap_data got=%0h exp=%0h", bus.m_data, 8'h10 + 8'(got)); end
            total++; if (xfer_cnt !== 4'(got)) begin bad++; $display("FAIL wrap_cnt_run got=%0d exp=%0d", xfer_cnt, 4'(got)); end
            got++;
         end
      end
      push = 1'b0;
      @(posedge clk);
      #1;
      total++; if (got != 17) begin bad++; $display("FAIL wrap_count got=%0d exp=17", got); end
      total++; if (xfer_cnt !== 4'd1) begin bad++; $display("FAIL wrap_final got=%0d exp=1", xfer_cnt); end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL wrap_underflow got=%0b exp=0", underflow); end
   endtask

   initial begin
      bus.m_ready = 1'b0;
      test_reset;
      test_stream;
      test_backpressure;
      test_empty;
      test_drain;
      test_reset_mid;
      test_wrap;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
